// File: rtl/vram_arbiter_if.sv
// Bundle of CPU pixel-op, video scan-out and VRAM port signals around vram_arbiter.
// slave = arbiter side, master = CPU / display timing / VRAM side.
interface vram_arbiter_if #(
    parameter int unsigned HBITS = 7,
    parameter int unsigned VBITS = 6,
    parameter int unsigned PIX_W = 2
);
    logic                     cpu_req;
    logic                     cpu_ready;
    logic [HBITS-1:0]         cpu_hpos;
    logic [VBITS-1:0]         cpu_vpos;
    logic [PIX_W-1:0]         cpu_pixel;
    logic                     cpu_xor;
    logic                     cpu_busy;
    logic                     collision;
    logic                     collision_clr;
    logic                     vid_req;
    logic [HBITS-1:0]         vid_hpos;
    logic [VBITS-1:0]         vid_vpos;
    logic [PIX_W-1:0]         vid_pixel;
    logic                     vid_valid;
    logic [HBITS+VBITS-1:0]   mem_addr;
    logic [PIX_W-1:0]         mem_din;
    logic [PIX_W-1:0]         mem_dout;
    logic                     mem_we;

    modport slave (
        input  cpu_req, cpu_hpos, cpu_vpos, cpu_pixel, cpu_xor, collision_clr,
               vid_req, vid_hpos, vid_vpos, mem_dout,
        output cpu_ready, cpu_busy, collision, vid_pixel, vid_valid,
               mem_addr, mem_din, mem_we
    );

    modport master (
        output cpu_req, cpu_hpos, cpu_vpos, cpu_pixel, cpu_xor, collision_clr,
               vid_req, vid_hpos, vid_vpos, mem_dout,
        input  cpu_ready, cpu_busy, collision, vid_pixel, vid_valid,
               mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video reads have absolute priority, queued CPU pixel ops
// retire through a read-modify-write FSM in the gaps, tracking a sticky XOR collision flag.
module vram_arbiter #(
    parameter int unsigned HBITS      = 7,
    parameter int unsigned VBITS      = 6,
    parameter int unsigned PIX_W      = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    vram_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [VBITS-1:0] vpos;
        logic [HBITS-1:0] hpos;
        logic [PIX_W-1:0] pixel;
        logic             is_xor;
    } op_t;

    typedef enum logic [1:0] {IDLE, READ, MODIFY, WRITE} state_t;

    op_t              fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q;
    op_t              op_q;
    logic [PIX_W-1:0] wdata_q;
    logic             collision_q;
    logic             vid_valid_q;

    logic             fifo_empty, fifo_full, cpu_ready, push, pop, coll_set;
    op_t              head, in_op;

    // FIFO bookkeeping; the FSM only pops from IDLE while video leaves the port free
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        cpu_ready  = rst_n && !fifo_full;
        push       = bus.cpu_req && cpu_ready;
        pop        = (state_q == IDLE) && !fifo_empty && !bus.vid_req;
        head       = fifo_q[rd_ptr_q];
        in_op      = '{vpos: bus.cpu_vpos, hpos: bus.cpu_hpos,
                       pixel: bus.cpu_pixel, is_xor: bus.cpu_xor};
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        coll_set   = (state_q == MODIFY) && (|bus.mem_dout) && (|op_q.pixel);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_op;
        end
    end

    // RMW sequencer; READ and WRITE stall whenever video owns the port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_q        <= '0;
            wdata_q     <= '0;
            collision_q <= 1'b0;
            vid_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            vid_valid_q <= bus.vid_req;
            collision_q <= coll_set || (collision_q && !bus.collision_clr);
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        op_q    <= head;
                        wdata_q <= head.pixel;
                        state_q <= head.is_xor ? READ : WRITE;
                    end
                end
                READ: begin
                    if (!bus.vid_req) begin
                        state_q <= MODIFY;
                    end
                end
                MODIFY: begin
                    wdata_q <= bus.mem_dout ^ op_q.pixel;
                    state_q <= WRITE;
                end
                WRITE: begin
                    if (!bus.vid_req) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Port mux: write enable is gated by reset so a held op is never issued while resetting
    assign bus.cpu_ready = cpu_ready;
    assign bus.cpu_busy  = !fifo_empty || (state_q != IDLE);
    assign bus.collision = collision_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_pixel = vid_valid_q ? bus.mem_dout : '0;
    assign bus.mem_addr  = bus.vid_req ? {bus.vid_vpos, bus.vid_hpos} : {op_q.vpos, op_q.hpos};
    assign bus.mem_din   = wdata_q;
    assign bus.mem_we    = rst_n && !bus.vid_req && (state_q == WRITE);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural 1-cycle-latency VRAM
// and a write log captured once per cycle.
module tb_vram_arbiter;
    localparam int unsigned HBITS  = 7;
    localparam int unsigned VBITS  = 6;
    localparam int unsigned PIX_W  = 2;
    localparam int unsigned ADDR_W = HBITS + VBITS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vram_arbiter_if #(.HBITS(HBITS), .VBITS(VBITS), .PIX_W(PIX_W)) bus ();

    vram_arbiter #(.HBITS(HBITS), .VBITS(VBITS), .PIX_W(PIX_W), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [PIX_W-1:0] vram [1 << ADDR_W] = '{default: '0};

    // Synchronous-read single-port VRAM
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) vram[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= vram[bus.mem_addr];
    end

    int n_checks = 0;
    int n_err    = 0;
    logic [ADDR_W+PIX_W-1:0] wlog [$];
    int   wbase;
    logic mon_en  = 1'b0;
    logic exp_vv  = 1'b0;
    logic [PIX_W-1:0] exp_vpix = '0;
    logic col_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe the current cycle at the falling edge, then advance to just after the next rising edge
    task automatic tick();
        @(negedge clk);
        if (mon_en) begin
            if (exp_vv) begin
                check("vid_valid", 32'(bus.vid_valid), 32'd1);
                check("vid_pixel", 32'(bus.vid_pixel), 32'(exp_vpix));
            end else begin
                check("vid_valid_idle", 32'(bus.vid_valid), 32'd0);
            end
            check("we_during_vid", 32'(bus.mem_we && bus.vid_req), 32'd0);
            if (bus.mem_we) wlog.push_back({bus.mem_addr, bus.mem_din});
        end
        exp_vv   = rst_n && bus.vid_req;
        exp_vpix = vram[{bus.vid_vpos, bus.vid_hpos}];
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int h, input int v, input int p, input int x);
        bus.cpu_req   = 1'b1;
        bus.cpu_hpos  = HBITS'(h);
        bus.cpu_vpos  = VBITS'(v);
        bus.cpu_pixel = PIX_W'(p);
        bus.cpu_xor   = 1'(x);
    endtask

    task automatic push_op(input int h, input int v, input int p, input int x);
        set_op(h, v, p, x);
        check("push_ready", 32'(bus.cpu_ready), 32'd1);
        tick();
        bus.cpu_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.cpu_busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(bus.cpu_busy), 32'd0);
    endtask

    task automatic check_wr(input string tag, input int idx, input int addr, input int din);
        if (wbase + idx < wlog.size()) begin
            check({tag, "_addr"}, 32'(wlog[wbase+idx][ADDR_W+PIX_W-1:PIX_W]), 32'(addr));
            check({tag, "_din"},  32'(wlog[wbase+idx][PIX_W-1:0]), 32'(din));
        end else begin
            check({tag, "_present"}, 32'(wlog.size() - wbase), 32'(idx + 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_hpos = '0; bus.cpu_vpos = '0; bus.cpu_pixel = '0;
        bus.cpu_xor = 1'b0; bus.collision_clr = 1'b0;
        bus.vid_req = 1'b0; bus.vid_hpos = '0; bus.vid_vpos = '0;

        // Reset values
        rst_n = 1'b0;
        repeat (3) tick();
        mon_en = 1'b1;
        check("rst_ready", 32'(bus.cpu_ready), 32'd0);
        check("rst_busy", 32'(bus.cpu_busy), 32'd0);
        check("rst_coll", 32'(bus.collision), 32'd0);
        check("rst_vvalid", 32'(bus.vid_valid), 32'd0);
        check("rst_vpix", 32'(bus.vid_pixel), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(bus.cpu_ready), 32'd1);
        tick();

        // 1: overwrite (10,5)=3
        wbase = wlog.size();
        push_op(10, 5, 3, 0);
        check("t1_busy", 32'(bus.cpu_busy), 32'd1);
        check("t1_we0", 32'(bus.mem_we), 32'd0);
        tick();
        check("t1_we", 32'(bus.mem_we), 32'd1);
        check("t1_addr", 32'(bus.mem_addr), 32'h28A);
        check("t1_din", 32'(bus.mem_din), 32'd3);
        tick();
        check("t1_busy_low", 32'(bus.cpu_busy), 32'd0);
        check("t1_nwrites", 32'(wlog.size() - wbase), 32'd1);

        // 2: XOR 3 onto stored 3 at (0,0)
        wbase = wlog.size();
        push_op(0, 0, 3, 0);
        push_op(0, 0, 3, 1);
        wait_idle(20);
        check_wr("t2_w0", 0, 0, 3);
        check_wr("t2_w1", 1, 0, 0);
        check("t2_coll", 32'(bus.collision), 32'd1);
        bus.collision_clr = 1'b1;
        tick();
        bus.collision_clr = 1'b0;
        check("t2_coll_clr", 32'(bus.collision), 32'd0);

        // 5: set and clear in the same cycle -> set wins
        wbase = wlog.size();
        bus.collision_clr = 1'b1;
        col_seen = 1'b0;
        push_op(1, 0, 2, 0);
        push_op(1, 0, 1, 1);
        for (int n = 0; n < 30 && bus.cpu_busy; n++) begin
            tick();
            if (bus.collision) col_seen = 1'b1;
        end
        check("t5_set_wins", 32'(col_seen), 32'd1);
        check("t5_cleared_after", 32'(bus.collision), 32'd0);
        bus.collision_clr = 1'b0;
        check_wr("t5_w1", 1, 1, 3);

        // 3: video holds the port while 4 ops queue up
        wbase = wlog.size();
        bus.vid_req = 1'b1; bus.vid_vpos = '0; bus.vid_hpos = '0;
        push_op(2, 1, 1, 0);
        push_op(2, 1, 2, 1);
        push_op(3, 1, 2, 0);
        push_op(3, 1, 2, 1);
        set_op(5, 5, 1, 0);
        check("t3_ready_full", 32'(bus.cpu_ready), 32'd0);
        tick();
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bus.vid_hpos = HBITS'(i);
            tick();
        end
        check("t3_no_writes", 32'(wlog.size() - wbase), 32'd0);
        check("t3_busy", 32'(bus.cpu_busy), 32'd1);
        bus.vid_req = 1'b0;
        wait_idle(40);
        check("t3_nwrites", 32'(wlog.size() - wbase), 32'd4);
        check_wr("t3_w0", 0, 'h82, 1);
        check_wr("t3_w1", 1, 'h82, 3);
        check_wr("t3_w2", 2, 'h83, 2);
        check_wr("t3_w3", 3, 'h83, 0);
        check("t3_coll", 32'(bus.collision), 32'd1);
        bus.collision_clr = 1'b1;
        tick();
        bus.collision_clr = 1'b0;

        // 4: video interleaved with an XOR op, hitting MODIFY and WRITE cycles
        wbase = wlog.size();
        push_op(4, 2, 1, 0);
        wait_idle(20);
        push_op(4, 2, 3, 1);
        for (int n = 0; n < 40 && bus.cpu_busy; n++) begin
            bus.vid_req  = (n % 3) != 0;
            bus.vid_hpos = (n % 2 == 0) ? HBITS'(4) : HBITS'(10);
            bus.vid_vpos = (n % 2 == 0) ? VBITS'(2) : VBITS'(5);
            tick();
        end
        bus.vid_req = 1'b0;
        check("t4_idle", 32'(bus.cpu_busy), 32'd0);
        check_wr("t4_w1", 1, 'h104, 2);
        check("t4_coll", 32'(bus.collision), 32'd1);
        bus.collision_clr = 1'b1;
        tick();
        bus.collision_clr = 1'b0;
        check("t4_coll_clr", 32'(bus.collision), 32'd0);

        // 6: reset while WRITE is held by video with 3 ops queued
        wbase = wlog.size();
        push_op(20, 20, 1, 0);
        set_op(21, 20, 1, 0);
        tick();
        bus.vid_req = 1'b1;
        set_op(22, 20, 1, 0);
        tick();
        set_op(23, 20, 1, 0);
        tick();
        bus.cpu_req = 1'b0;
        check("t6_held_we", 32'(bus.mem_we), 32'd0);
        check("t6_busy", 32'(bus.cpu_busy), 32'd1);
        rst_n = 1'b0;
        bus.vid_req = 1'b0;
        #1;
        check("t6_we_in_rst", 32'(bus.mem_we), 32'd0);
        tick();
        check("t6_rst_busy", 32'(bus.cpu_busy), 32'd0);
        check("t6_rst_ready", 32'(bus.cpu_ready), 32'd0);
        check("t6_rst_coll", 32'(bus.collision), 32'd0);
        check("t6_rst_vvalid", 32'(bus.vid_valid), 32'd0);
        check("t6_rst_vpix", 32'(bus.vid_pixel), 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("t6_no_write", 32'(wlog.size() - wbase), 32'd0);
        check("t6_empty", 32'(bus.cpu_busy), 32'd0);
        check("t6_ready", 32'(bus.cpu_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
